mau_scheduler: RTL and testbench
================================

MAU_SCHEDULER -- requirements
Module: mau_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries; power of two, at least 2.
REQ-002 Parameter BUSY_ACK_CYCLES, default 4: cycles to wait for mau_busy to rise after issue.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles in WAIT_DONE; used only when MAU_SCHED_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single clock; all logic updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req0_valid  in  1  requester 0 holds a command.
REQ-007 req0_instr  in  8  requester 0 MAU instruction.
REQ-008 req0_ready  out  1  requester 0 command accepted this cycle when valid is also high.
REQ-009 req1_valid, req1_instr, req1_ready  in/in/out  1/8/1  requester 1, same meanings as REQ-006 to REQ-008.
REQ-010 mau_instr  out  8  registered instruction to MAU host_instruction; 8'h00 (NOP) when not issuing.
REQ-011 mau_busy  in  1  MAU busy_flag.
REQ-012 done  out  1  one-cycle pulse when an issued command completes.
REQ-013 done_id  out  1  requester of the completed command; valid while done=1.
REQ-014 sched_busy  out  1  high when FIFO non-empty or state is not IDLE.
REQ-015 timeout_err  out  1  sticky watchdog flag.

Function
REQ-016 Valid/ready: a push occurs when reqN_valid and reqN_ready are both high; requesters hold valid and instr stable until accepted.
REQ-017 reqN_ready = !fifo_full && grant==N; at most one push per cycle; fifo_full is registered, so no push while full, even with a same-cycle pop.
REQ-018 Round-robin grant: if both are valid, grant the requester not granted last; if one is valid, grant it; the pointer updates only on a push.
REQ-019 FIFO stores {id, instr} in order; the entry is visible at the head the cycle after the push.
REQ-020 FSM states are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE -> ISSUE when the FIFO is non-empty and mau_busy=0; otherwise stay in IDLE.
REQ-022 In the ISSUE state, mau_instr=head instr for exactly one cycle, the head is popped, the id is latched, and the next state is WAIT_BUSY with wait counter=0.
REQ-023 WAIT_BUSY: if mau_busy=1, go to WAIT_DONE; else if counter=BUSY_ACK_CYCLES-1, complete and go to IDLE (single-cycle instruction); else increment the counter.
REQ-024 WAIT_DONE: when mau_busy=0, complete and go to IDLE.
REQ-025 Completion asserts done=1 and done_id=latched id for exactly the cycle after the completing edge.
REQ-026 Latency: with an empty FIFO, IDLE state and mau_busy=0, a command pushed at edge k appears on mau_instr in cycle k+2.
REQ-027 Back-to-back: the next issue needs IDLE again; the minimum spacing is 3 cycles between issues.
REQ-028 mau_instr is 8'h00 in every state except ISSUE.

Reset
REQ-029 With rst=0 at an edge: state=IDLE, FIFO empty, RR pointer favours req0, mau_instr=8'h00, done=0, done_id=0, timeout_err=0, counters=0.
REQ-030 Reset mid-operation drops the in-flight and queued commands with no done pulse; the MAU itself is not reset by this block.
REQ-031 While rst=0, reqN_ready=0.

Configuration
REQ-032 With MAU_SCHED_TIMEOUT_EN defined:
- A WAIT_DONE counter runs.
- When it reaches TIMEOUT_CYCLES-1 with mau_busy still 1, timeout_err sets (sticky until reset) and completion proceeds with a done pulse, returning to IDLE.
REQ-033 Without MAU_SCHED_TIMEOUT_EN:
- The timeout_err port remains, tied to 0.
- WAIT_DONE waits indefinitely.
- No timeout counter is synthesized.

Structure
REQ-034 Package mau_sched_pkg holds the state enum, the MAU_NOP=8'h00 constant and the FIFO entry width (9).
REQ-035 The FIFO is the sub-module mau_cmd_fifo (synchronous, registered full/empty, parameterized depth/width); arbiter and FSM live in mau_scheduler.

Verification
REQ-036 Single command: req0 pushes 8'h12, mau_busy rises 1 cycle after issue and is held 10 cycles -> mau_instr=8'h12 in cycle k+2 only; done=1 with done_id=0 one cycle after mau_busy falls.
REQ-037 Contention: req0 and req1 are both valid continuously with 8'hA0 and 8'hB1 -> grants alternate starting with req0; issue order is A0, B1, A0, B1.
REQ-038 Full FIFO: mau_busy held at 1, 5 pushes attempted with FIFO_DEPTH=4 -> 4 accepted; the 5th ready=0 until the first pop; no entry is lost or duplicated.
REQ-039 No busy acknowledge: mau_busy stays 0 after issuing 8'h05 -> done pulses after BUSY_ACK_CYCLES=4 cycles in WAIT_BUSY.
REQ-040 Reset mid-operation: rst=0 during WAIT_DONE with 2 queued commands -> next cycle state IDLE, FIFO empty, mau_instr=00, no done.
REQ-041 Timeout (macro defined, TIMEOUT_CYCLES=16): mau_busy stuck at 1 -> timeout_err=1 and done after 16 WAIT_DONE cycles; the flag is still 1 after the next command completes.

Source files
------------

// File: rtl/mau_sched_pkg.sv
// Shared types and constants for the MAU command scheduler: FSM state encoding,
// the NOP instruction and the {id, instr} layout of a queued command.
package mau_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  localparam logic [7:0] MAU_NOP = 8'h00;
  localparam int unsigned ENTRY_W = 9;

  typedef struct packed {
    logic       id;
    logic [7:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/mau_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; the head entry is
// visible on dout_o the cycle after it is pushed.
module mau_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push_i && !full_q;
  assign do_pop_s  = pop_i && !empty_q;

  // Pointer, occupancy and flag next-state; flags are derived from the next count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1'b1);
      2'b01:   count_d = count_q - (AW+1)'(1'b1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are meaningless while empty so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/mau_scheduler.sv
// Two-requester round-robin front end feeding a command FIFO and an issue FSM
// that drives the MAU. Optional watchdog in WAIT_DONE under MAU_SCHED_TIMEOUT_EN.
module mau_scheduler
  import mau_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned BUSY_ACK_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_instr,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_instr,
  output logic       req1_ready,
  output logic [7:0] mau_instr,
  input  logic       mau_busy,
  output logic       done,
  output logic       done_id,
  output logic       sched_busy,
  output logic       timeout_err
);

  localparam int unsigned BW = $clog2(BUSY_ACK_CYCLES + 32'd1);

  logic        prio_q, prio_d;
  logic        grant_s;
  logic        push_s;
  logic        pop_s;
  fifo_entry_t push_entry_s;
  fifo_entry_t head_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;

  state_e      state_q, state_d;
  logic [BW-1:0] ack_cnt_q, ack_cnt_d;
  logic        id_q, id_d;
  logic [7:0]  mau_instr_q, mau_instr_d;
  logic        done_q, done_d;
  logic        done_id_q, done_id_d;
  logic        complete_s;
  logic        to_hit_s;

  // Round-robin grant: prio_q names the requester favoured on contention
  always_comb begin
    grant_s = prio_q;
    if (req0_valid && req1_valid) begin
      grant_s = prio_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else if (req0_valid) begin
      grant_s = 1'b0;
    end else begin
      grant_s = prio_q;
    end
  end

  assign req0_ready = rst && !fifo_full_s && (grant_s == 1'b0);
  assign req1_ready = rst && !fifo_full_s && (grant_s == 1'b1);
  assign push_s     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign push_entry_s.id    = grant_s;
  assign push_entry_s.instr = grant_s ? req1_instr : req0_instr;
  assign prio_d             = push_s ? ~grant_s : prio_q;

  mau_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .din_i   (push_entry_s),
    .pop_i   (pop_s),
    .dout_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Issue FSM next-state and completion decode
  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = ack_cnt_q;
    id_d       = id_q;
    pop_s      = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s && !mau_busy) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        pop_s     = 1'b1;
        id_d      = head_s.id;
        ack_cnt_d = '0;
        state_d   = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (mau_busy) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == BW'(BUSY_ACK_CYCLES - 32'd1)) begin
          complete_s = 1'b1;
          state_d    = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + BW'(1'b1);
        end
      end
      S_WAIT_DONE: begin
        if (!mau_busy || to_hit_s) begin
          complete_s = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // mau_instr is registered, so it is loaded as the FSM enters ISSUE
    mau_instr_d = (state_d == S_ISSUE) ? head_s.instr : MAU_NOP;
    done_d      = complete_s;
    done_id_d   = complete_s ? id_q : done_id_q;
  end

  // FSM, arbiter pointer and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ack_cnt_q   <= '0;
      id_q        <= 1'b0;
      prio_q      <= 1'b0;
      mau_instr_q <= MAU_NOP;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_cnt_q   <= ack_cnt_d;
      id_q        <= id_d;
      prio_q      <= prio_d;
      mau_instr_q <= mau_instr_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
    end
  end

`ifdef MAU_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 32'd1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;

  // Watchdog counts WAIT_DONE cycles and forces completion when it expires
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    to_hit_s  = 1'b0;
    if (state_q == S_WAIT_DONE) begin
      if (mau_busy && (to_cnt_q == TW'(TIMEOUT_CYCLES - 32'd1))) begin
        to_hit_s  = 1'b1;
        timeout_d = 1'b1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1'b1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Watchdog registers; the error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  logic unused_timeout_s;

  assign to_hit_s         = 1'b0;
  assign timeout_err      = 1'b0;
  assign unused_timeout_s = (TIMEOUT_CYCLES == 32'd0);
`endif

  assign mau_instr  = mau_instr_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign sched_busy = !fifo_empty_s || (state_q != S_IDLE);

endmodule

// File: tb/tb_mau_scheduler.sv
// Directed self-checking bench for mau_scheduler; inputs are driven and outputs
// sampled around the falling clock edge.
module tb_mau_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_instr, req1_instr;
  logic       req0_ready, req1_ready;
  logic [7:0] mau_instr;
  logic       mau_busy;
  logic       done, done_id, sched_busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mau_scheduler #(
    .FIFO_DEPTH      (4),
    .BUSY_ACK_CYCLES (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_instr  (req0_instr),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_instr  (req1_instr),
    .req1_ready  (req1_ready),
    .mau_instr   (mau_instr),
    .mau_busy    (mau_busy),
    .done        (done),
    .done_id     (done_id),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_instr = 8'h00; req1_instr = 8'h00; mau_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_instr = 8'h3C; req1_instr = 8'h4D; mau_busy = 1'b0;
    @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    checks++; if (mau_instr !== 8'h00) begin failures++; $display("FAIL reset_mau_instr got=%h exp=00", mau_instr); end
    checks++; if ({done, done_id} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {done, done_id}); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL reset_sched_busy got=%b exp=0", sched_busy); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL reset_rr_favours_req0 got=%b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL reset_no_push got=%b exp=0", sched_busy); end
  endtask

  task automatic test_single();
    bit early = 1'b0;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_instr = 8'h12;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (mau_instr !== 8'h00) begin failures++; $display("FAIL single_k1_nop got=%h exp=00", mau_instr); end
    checks++; if (sched_busy !== 1'b1) begin failures++; $display("FAIL single_sched_busy got=%b exp=1", sched_busy); end
    @(negedge clk);
    checks++; if (mau_instr !== 8'h12) begin failures++; $display("FAIL single_issue_k2 got=%h exp=12", mau_instr); end
    @(negedge clk);
    checks++; if (mau_instr !== 8'h00) begin failures++; $display("FAIL single_issue_one_cycle got=%h exp=00", mau_instr); end
    mau_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || mau_instr !== 8'h00) early = 1'b1;
    end
    mau_busy = 1'b0;
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL single_quiet_while_busy got=%b exp=0", early); end
    @(negedge clk);
    checks++; if ({done, done_id} !== 2'b10) begin failures++; $display("FAIL single_done got=%b exp=10", {done, done_id}); end
    @(negedge clk);
    checks++; if ({done, sched_busy} !== 2'b00) begin failures++; $display("FAIL single_done_pulse_end got=%b exp=00", {done, sched_busy}); end
  endtask

  task automatic test_contention();
    logic [7:0] iss[16];
    int         iss_cyc[16];
    bit         gr[4];
    bit         did[4];
    int n_iss = 0, n_g = 0, n_d = 0, min_gap = 1000;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_instr = 8'hA0;
    req1_valid = 1'b1; req1_instr = 8'hB1;
    for (int c = 0; c < 80; c++) begin
      #1;
      if ((req0_ready || req1_ready) && n_g < 4) begin gr[n_g] = req1_ready; n_g++; end
      if (mau_instr !== 8'h00 && n_iss < 16) begin iss[n_iss] = mau_instr; iss_cyc[n_iss] = c; n_iss++; end
      if (done === 1'b1 && n_d < 4) begin did[n_d] = done_id; n_d++; end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (n_iss < 4 || n_d < 4 || n_g < 4) begin failures++; $display("FAIL cont_counts got iss=%0d done=%0d grants=%0d exp>=4 each", n_iss, n_d, n_g); end
    if (n_iss >= 4 && n_d >= 4 && n_g >= 4) begin
      checks++; if ({gr[0], gr[1], gr[2], gr[3]} !== 4'b0101) begin failures++; $display("FAIL cont_grants got=%b exp=0101", {gr[0], gr[1], gr[2], gr[3]}); end
      checks++; if ({iss[0], iss[1], iss[2], iss[3]} !== 32'hA0B1A0B1) begin failures++; $display("FAIL cont_issue_order got=%h exp=a0b1a0b1", {iss[0], iss[1], iss[2], iss[3]}); end
      checks++; if ({did[0], did[1], did[2], did[3]} !== 4'b0101) begin failures++; $display("FAIL cont_done_ids got=%b exp=0101", {did[0], did[1], did[2], did[3]}); end
      for (int i = 1; i < n_iss; i++) if (iss_cyc[i] - iss_cyc[i-1] < min_gap) min_gap = iss_cyc[i] - iss_cyc[i-1];
      checks++; if (min_gap < 3) begin failures++; $display("FAIL cont_issue_spacing got=%0d exp>=3", min_gap); end
    end
  endtask

  task automatic test_full();
    logic [7:0] iss[8];
    int n_iss = 0, first_iss = -1, acc_cyc = -1;
    bit acc_bad = 1'b0, blocked_bad = 1'b0;
    do_reset();
    @(negedge clk);
    mau_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req0_valid = 1'b1; req0_instr = 8'(i);
      #1;
      if (req0_ready !== 1'b1) acc_bad = 1'b1;
      @(negedge clk);
    end
    req0_instr = 8'h05;
    #1;
    checks++; if (acc_bad !== 1'b0) begin failures++; $display("FAIL full_first4_accepted got=%b exp=0", acc_bad); end
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL full_5th_blocked got=%b exp=0", req0_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (req0_ready !== 1'b0 || mau_instr !== 8'h00) blocked_bad = 1'b1;
    end
    checks++; if (blocked_bad !== 1'b0) begin failures++; $display("FAIL full_held_while_busy got=%b exp=0", blocked_bad); end
    @(negedge clk);
    mau_busy = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (mau_instr !== 8'h00 && n_iss < 8) begin
        if (n_iss == 0) first_iss = c;
        iss[n_iss] = mau_instr; n_iss++;
      end
      if (req0_valid && req0_ready && acc_cyc < 0) acc_cyc = c;
      @(negedge clk);
      if (acc_cyc >= 0) req0_valid = 1'b0;
    end
    checks++; if (acc_cyc !== first_iss + 1) begin failures++; $display("FAIL full_5th_after_pop got=%0d exp=%0d", acc_cyc, first_iss + 1); end
    checks++; if (n_iss !== 5) begin failures++; $display("FAIL full_issue_count got=%0d exp=5", n_iss); end
    if (n_iss == 5) begin
      checks++; if ({iss[0], iss[1], iss[2], iss[3], iss[4]} !== 40'h0102030405) begin failures++; $display("FAIL full_issue_order got=%h exp=0102030405", {iss[0], iss[1], iss[2], iss[3], iss[4]}); end
    end
    checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", sched_busy); end
  endtask

  task automatic test_noack();
    bit early = 1'b0;
    do_reset();
    @(negedge clk);
    req1_valid = 1'b1; req1_instr = 8'h05;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL noack_grant_lone got=%b exp=01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    checks++; if (mau_instr !== 8'h05) begin failures++; $display("FAIL noack_issue got=%h exp=05", mau_instr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL noack_wait_4 got=%b exp=0", early); end
    @(negedge clk);
    checks++; if ({done, done_id} !== 2'b11) begin failures++; $display("FAIL noack_done got=%b exp=11", {done, done_id}); end
  endtask

  task automatic test_reset_mid();
    bit acc_bad = 1'b0, quiet_bad = 1'b0;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_instr = 8'h11;
    #1; if (req0_ready !== 1'b1) acc_bad = 1'b1;
    @(negedge clk);
    req0_instr = 8'h22;
    #1; if (req0_ready !== 1'b1) acc_bad = 1'b1;
    @(negedge clk);
    mau_busy = 1'b1;
    if (mau_instr !== 8'h11) acc_bad = 1'b1;
    req0_instr = 8'h33;
    #1; if (req0_ready !== 1'b1) acc_bad = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (acc_bad !== 1'b0 || sched_busy !== 1'b1) begin failures++; $display("FAIL mid_setup got=%b/%b exp=0/1", acc_bad, sched_busy); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if ({mau_instr, done, sched_busy} !== 10'h000) begin failures++; $display("FAIL mid_reset_idle got=%h exp=000", {mau_instr, done, sched_busy}); end
    @(negedge clk);
    @(negedge clk);
    mau_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mau_instr !== 8'h00 || done !== 1'b0 || sched_busy !== 1'b0) quiet_bad = 1'b1;
    end
    checks++; if (quiet_bad !== 1'b0) begin failures++; $display("FAIL mid_queue_dropped got=%b exp=0", quiet_bad); end
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    int n_done = 0;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_instr = 8'h77;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (mau_instr !== 8'h77) begin failures++; $display("FAIL to_issue got=%h exp=77", mau_instr); end
    mau_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || timeout_err !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_not_before_16 got=%b exp=0", early); end
    @(negedge clk);
`ifdef MAU_SCHED_TIMEOUT_EN
    checks++; if ({done, timeout_err} !== 2'b11) begin failures++; $display("FAIL to_expire got=%b exp=11", {done, timeout_err}); end
`else
    checks++; if ({done, timeout_err, sched_busy} !== 3'b001) begin failures++; $display("FAIL to_disabled_waits got=%b exp=001", {done, timeout_err, sched_busy}); end
`endif
    mau_busy = 1'b0;
    req1_valid = 1'b1; req1_instr = 8'h78;
    @(negedge clk);
    req1_valid = 1'b0;
    if (done === 1'b1) n_done++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
`ifdef MAU_SCHED_TIMEOUT_EN
    checks++; if (n_done !== 1) begin failures++; $display("FAIL to_next_done got=%0d exp=1", n_done); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", timeout_err); end
`else
    checks++; if (n_done !== 2) begin failures++; $display("FAIL to_next_done got=%0d exp=2", n_done); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_tied_low got=%b exp=0", timeout_err); end
`endif
  endtask

  initial begin
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_instr = 8'h00; req1_instr = 8'h00; mau_busy = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_noack();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
